// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter feeding the apb_master request port
//
// Shares apb_master's single valid/ready descriptor port between NREQ
// requesters. The winner's descriptor is registered and held until accepted.
// Zero-length descriptors are acknowledged but never forwarded.
//
// Optional build macro: APB_ARB_TIMEOUT_EN (drop a descriptor stalled for
// TIMEOUT_CYCLES and pulse timeout_err).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid         per-requester descriptor valid
//   req_ready         one-hot capture pulse back to the requester
//   req_source        packed 8-bit sources, requester i at [8i+7:8i]
//   req_destination   packed 8-bit destinations, requester i at [8i+7:8i]
//   req_length        packed 4-bit lengths, requester i at [4i+3:4i]
//   valid, ready      handshake toward apb_master
//   source, destination, length  registered granted descriptor
//   grant_id          index of the requester whose descriptor is on the output
//   busy              mirrors valid
//   timeout_err       one-cycle pulse on a stall timeout drop
module apb_req_arbiter #(
  parameter int NREQ           = 4,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_source,
  input  logic [NREQ*8-1:0] req_destination,
  input  logic [NREQ*4-1:0] req_length,
  output logic              valid,
  input  logic              ready,
  output logic [7:0]        source,
  output logic [7:0]        destination,
  output logic [3:0]        length,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] win;
  logic           found;
  logic           capture;
  logic           stall_expired;
  logic [7:0]     win_src;
  logic [7:0]     win_dst;
  logic [3:0]     win_len;

  // A new descriptor may be taken when idle, or in the same cycle the held
  // one is accepted. Reset closes the window so no req_ready leaks out.
  assign capture = !rst && ((state == IDLE) || ((state == HOLD) && ready));

  // Round-robin search starting just after the last winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_valid[(int'(last_grant) + k) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(last_grant) + k) % NREQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (capture && found) req_ready[win] = 1'b1;
  end

  assign win_src = req_source[8*win +: 8];
  assign win_dst = req_destination[8*win +: 8];
  assign win_len = req_length[4*win +: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= IDW'(NREQ - 1);
      source      <= '0;
      destination <= '0;
      length      <= '0;
      grant_id    <= '0;
    end else if (capture && found) begin
      last_grant <= win;
      if (win_len != 4'd0) begin
        state       <= HOLD;
        source      <= win_src;
        destination <= win_dst;
        length      <= win_len;
        grant_id    <= win;
      end else begin
        // Zero length: acknowledged to the requester but never forwarded.
        state <= IDLE;
      end
    end else if (capture || stall_expired) begin
      state <= IDLE;
    end
  end

  assign valid = (state == HOLD);
  assign busy  = valid;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] stall_cnt;
  logic          timeout_q;

  // A ready on the final stall cycle wins over the timeout.
  assign stall_expired = (state == HOLD) && !ready &&
                         (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= stall_expired;
      // Cleared whenever not stalling, so every HOLD entry starts from zero.
      if ((state != HOLD) || ready) stall_cnt <= '0;
      else                          stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign stall_expired = 1'b0;
  // Constant 0; the parameter term only keeps TIMEOUT_CYCLES referenced.
  assign timeout_err   = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Round-robin arbiter that shares the single upstream request port of apb_master between NREQ independent requesters.
- Each requester presents a transfer descriptor (source, destination, length). The arbiter picks one, registers it and drives apb_master's valid/ready interface until accepted.
- Sits directly in front of apb_master. Its downstream outputs connect 1:1 to apb_master valid/ready/source/destination/length.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of grant_id; must be >= clog2(NREQ).
- TIMEOUT_CYCLES, 64, downstream stall limit in cycles; used only when APB_ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester descriptor valid.
- req_ready  output  NREQ  one-hot pulse: descriptor of requester i captured this cycle.
- req_source  input  NREQ*8  packed sources, requester i at [8i+7:8i].
- req_destination  input  NREQ*8  packed destinations, requester i at [8i+7:8i].
- req_length  input  NREQ*4  packed lengths, requester i at [4i+3:4i].
- valid  output  1  to apb_master: descriptor valid.
- ready  input  1  from apb_master: descriptor accepted.
- source  output  8  registered source of the granted descriptor.
- destination  output  8  registered destination of the granted descriptor.
- length  output  4  registered length of the granted descriptor.
- grant_id  output  IDW  index of the requester whose descriptor is on the output.
- busy  output  1  high while valid is high.
- timeout_err  output  1  one-cycle pulse on timeout drop; tied 0 when APB_ARB_TIMEOUT_EN is not defined.

Behaviour:
- Reset (rst high at a clk edge):
  - All outputs go to 0: valid, req_ready, source, destination, length, grant_id, busy, timeout_err.
  - The round-robin pointer last_grant is set to NREQ-1, so requester 0 wins first.
  - Any held descriptor is discarded. Reset mid-transfer drops it silently and issues no req_ready.
- FSM states:
  - IDLE: valid=0.
  - HOLD: valid=1; source, destination, length and grant_id stable.
- Capture window, when a descriptor can be captured:
  - state == IDLE, or
  - state == HOLD and valid && ready (back-to-back).
- Arbitration in the capture window:
  - Search req_valid starting at (last_grant+1) mod NREQ, wrapping, and take the first requester found.
  - For the winner w: req_ready[w] = 1 (combinational, same cycle). Its descriptor is registered at that edge and last_grant <= w.
- Zero-length descriptor:
  - Captured and acknowledged (req_ready pulse, last_grant advances).
  - Not forwarded; next state is IDLE.
- Non-zero-length descriptor: next state is HOLD, with valid=1 from the following cycle.
- Latency: req_valid to valid is 1 cycle. Back-to-back grants give one descriptor per cycle when ready is held high.
- Handshake completes on valid && ready. With no new winner in the capture window, HOLD goes to IDLE.
- In HOLD without ready, outputs must not change. A requester deasserting req_valid after capture has no effect.
- At most one bit of req_ready is high in any cycle. req_ready is 0 outside the capture window.
- busy equals valid.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- When defined:
  - A stall counter resets to 0 on entry to HOLD and increments each HOLD cycle without ready.
  - When it reaches TIMEOUT_CYCLES-1 without ready, the next edge drops the descriptor: valid=0, state goes to IDLE, and timeout_err pulses for 1 cycle.
  - A ready in that same cycle takes precedence: normal completion, no error.
- When not defined: no counter is built, timeout_err is constant 0, and HOLD waits indefinitely.

Test Plan:
- Reset priority: after rst, req_valid=4'b1111, ready=1 → grants in order 0,1,2,3,0. One req_ready bit per cycle; grant_id follows 0,1,2,3,0.
- Fairness: req_valid=4'b0101 held, ready=1 → grants alternate 0,2,0,2; requesters 1 and 3 never granted.
- Stall hold: req0 {src=8'h12, dst=8'h34, len=4'h5}, ready=0 for 10 cycles → valid, source, destination, length stable for 10 cycles. On ready=1, one handshake occurs, then valid=0 next cycle.
- Zero-length drop: req1 len=0, then req2 len=3 → req_ready[1] pulses and valid never rises for req1. req2 appears with length=3 and grant_id=2.
- Reset mid-HOLD: rst asserted while valid=1, ready=0 → next cycle valid=0 with no req_ready. After release, requester 0 wins first again.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): ready held 0 → valid drops after exactly 8 HOLD cycles and timeout_err is high for 1 cycle. Repeated with ready=1 on the 8th cycle → normal handshake, timeout_err=0.
